wb_slave_mem_if: RTL and testbench

- Wishbone B4 classic-cycle slave front-end. Sits directly upstream of the memory-controller FSM.
- Accepts bus cycles from the processor's Wishbone master.
- Latches address, write data and byte selects.
- Drives the controller's ack, read-enable and write-enable inputs for a fixed memory access window.
- Returns read data to the bus with a single-cycle wb_ack_o.

---
 rtl/wb_slave_mem_if.sv | 124 ++++++++++++
 tb/tb_wb_slave_mem_if.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem_if.sv
// wb_slave_mem_if: Wishbone B4 classic slave front-end that opens a fixed access window on the memory controller.
// Optional out-of-range error response is enabled by defining WB_SLAVE_ERR_EN.
module wb_slave_mem_if #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 2
`ifdef WB_SLAVE_ERR_EN
  ,parameter logic [AW-1:0] ADDR_LIMIT = 'h0000_4000
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            ctrl_ack,
  output logic            read_en_to_ctrl,
  output logic            write_en_to_ctrl,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
`ifdef WB_SLAVE_ERR_EN
  ,output logic           wb_err_o
`endif
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d, rdat_q, rdat_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            ack_q, ack_d, ctrl_q, ctrl_d, ren_q, ren_d, wen_q, wen_d;
  logic            req, bad;
  assign req = wb_cyc_i & wb_stb_i;
`ifdef WB_SLAVE_ERR_EN
  logic err_q, err_d;
  assign bad      = wb_adr_i >= ADDR_LIMIT;
  assign err_d    = (state_d == RESP) && (state_q == IDLE);
  assign wb_err_o = err_q;
`else
  assign bad = 1'b0;
`endif
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: if (req) begin
        if (bad) state_d = RESP;
        else begin
          state_d = ACCESS;
          cnt_d   = CW'(MEM_LATENCY - 1);
          we_d    = wb_we_i;
          adr_d   = wb_adr_i;
          wdat_d  = wb_dat_i;
          sel_d   = wb_sel_i;
        end
      end
      ACCESS: if (!wb_cyc_i) state_d = IDLE;
        else if (cnt_q == '0) begin
          state_d = RESP;
          rdat_d  = we_q ? rdat_q : mem_rdata;
        end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    ctrl_d = state_d == ACCESS;
    ren_d  = ctrl_d & ~we_d;
    wen_d  = ctrl_d & we_d;
    ack_d  = (state_d == RESP) && (state_q == ACCESS);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
`ifdef WB_SLAVE_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      ctrl_q  <= ctrl_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
`ifdef WB_SLAVE_ERR_EN
      err_q   <= err_d;
`endif
    end
  assign wb_dat_o         = rdat_q;
  assign wb_ack_o         = ack_q;
  assign ctrl_ack         = ctrl_q;
  assign read_en_to_ctrl  = ren_q;
  assign write_en_to_ctrl = wen_q;
  assign mem_addr         = adr_q;
  assign mem_wdata        = wdat_q;
  assign mem_be           = sel_q;
endmodule

// File: tb/tb_wb_slave_mem_if.sv
// tb_wb_slave_mem_if: directed bench for wb_slave_mem_if with a transfer-schedule reference model.
module tb_wb_slave_mem_if;
  localparam int L = 2;
  logic        clk = 0;
  logic        reset = 1;
  logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
  logic [31:0] wb_adr_i = 0, wb_dat_i = 0, mem_rdata = 0;
  logic [3:0]  wb_sel_i = 0;
  logic [31:0] wb_dat_o, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        wb_ack_o, ctrl_ack, read_en_to_ctrl, write_en_to_ctrl;
`ifdef WB_SLAVE_ERR_EN
  logic        wb_err_o;
`endif
  int compared = 0;
  int mismatched = 0;

  wb_slave_mem_if #(.AW(32), .DW(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .ctrl_ack(ctrl_ack),
    .read_en_to_ctrl(read_en_to_ctrl), .write_en_to_ctrl(write_en_to_ctrl),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata)
`ifdef WB_SLAVE_ERR_EN
    ,.wb_err_o(wb_err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
    end
  endtask

  // Reference model: a transfer accepted at edge s owns edges s+1..s+L; completion at s+L
  // gives a one-cycle ack, and the slave is deaf for one more edge while responding.
  int          e = 0, s = 0, free_at = 0;
  bit          m_act = 0, m_we = 0, m_ack = 0, m_err = 0;
  logic [31:0] m_dat = 0, m_adr = 0, m_wd = 0;
  logic [3:0]  m_be = 0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      e <= 0; s <= 0; free_at <= 0;
      m_act <= 0; m_we <= 0; m_ack <= 0; m_err <= 0;
      m_dat <= 0; m_adr <= 0; m_wd <= 0; m_be <= 0;
    end else begin
      e <= e + 1;
      m_ack <= 0;
      m_err <= 0;
      if (m_act) begin
        if (!wb_cyc_i) begin
          m_act <= 0;
          free_at <= e + 1;
        end else if (e == s + L) begin
          m_act <= 0;
          m_ack <= 1;
          free_at <= e + 2;
          if (!m_we) m_dat <= mem_rdata;
        end
      end else if (e >= free_at && wb_cyc_i && wb_stb_i) begin
`ifdef WB_SLAVE_ERR_EN
        if (wb_adr_i >= 32'h4000) begin
          m_err <= 1;
          free_at <= e + 2;
        end else
`endif
        begin
          m_act <= 1; s <= e; m_we <= wb_we_i;
          m_adr <= wb_adr_i; m_wd <= wb_dat_i; m_be <= wb_sel_i;
        end
      end
    end

  always @(negedge clk) begin
    chk("m_ctrl", ctrl_ack, m_act);
    chk("m_ren", read_en_to_ctrl, m_act & ~m_we);
    chk("m_wen", write_en_to_ctrl, m_act & m_we);
    chk("m_ack", wb_ack_o, m_ack);
    chk("m_dat", wb_dat_o, m_dat);
    chk("m_adr", mem_addr, m_adr);
    chk("m_wdata", mem_wdata, m_wd);
    chk("m_be", mem_be, m_be);
    chk("m_excl", read_en_to_ctrl & write_en_to_ctrl, 0);
`ifdef WB_SLAVE_ERR_EN
    chk("m_err", wb_err_o, m_err);
`endif
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d; wb_sel_i = sl;
  endtask

  task automatic idle();
    wb_cyc_i = 0; wb_stb_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic ackv [1:8];
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_ctrl", ctrl_ack, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_adr", mem_addr, 0);
    reset = 0;
    @(negedge clk);
    // read
    mem_rdata = 32'hDEADBEEF;
    drive(0, 32'h10, 0, 4'hF);
    @(negedge clk);
    chk("rd_c1_ren", read_en_to_ctrl, 1);
    chk("rd_c1_ctrl", ctrl_ack, 1);
    chk("rd_c1_adr", mem_addr, 32'h10);
    @(negedge clk);
    chk("rd_c2_ren", read_en_to_ctrl, 1);
    chk("rd_c2_ack", wb_ack_o, 0);
    @(negedge clk);
    chk("rd_c3_ack", wb_ack_o, 1);
    chk("rd_c3_dat", wb_dat_o, 32'hDEADBEEF);
    chk("rd_c3_ren", read_en_to_ctrl, 0);
    idle();
    @(negedge clk);
    chk("rd_c4_ack", wb_ack_o, 0);
    // write
    mem_rdata = 32'hCAFEF00D;
    drive(1, 32'h20, 32'h12345678, 4'b0011);
    @(negedge clk);
    chk("wr_c1_wen", write_en_to_ctrl, 1);
    chk("wr_c1_ren", read_en_to_ctrl, 0);
    chk("wr_c1_wdata", mem_wdata, 32'h12345678);
    chk("wr_c1_be", mem_be, 4'b0011);
    @(negedge clk);
    chk("wr_c2_wen", write_en_to_ctrl, 1);
    @(negedge clk);
    chk("wr_c3_ack", wb_ack_o, 1);
    chk("wr_c3_dat", wb_dat_o, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    // abort
    mem_rdata = 32'h11112222;
    drive(0, 32'h30, 0, 4'hF);
    @(negedge clk);
    chk("ab_c1_ren", read_en_to_ctrl, 1);
    idle();
    @(negedge clk);
    chk("ab_c2_ren", read_en_to_ctrl, 0);
    chk("ab_c2_ctrl", ctrl_ack, 0);
    chk("ab_c2_ack", wb_ack_o, 0);
    @(negedge clk);
    chk("ab_c3_ack", wb_ack_o, 0);
    chk("ab_c3_dat", wb_dat_o, 32'hDEADBEEF);
    chk("ab_c3_adr", mem_addr, 32'h30);
    // strobe dropped mid-window
    mem_rdata = 32'h5555AAAA;
    drive(0, 32'h40, 0, 4'hF);
    @(negedge clk);
    wb_stb_i = 0;
    @(negedge clk);
    chk("stb_c2_ren", read_en_to_ctrl, 1);
    @(negedge clk);
    chk("stb_c3_ack", wb_ack_o, 1);
    chk("stb_c3_dat", wb_dat_o, 32'h5555AAAA);
    idle();
    @(negedge clk);
    // asynchronous reset mid-window
    mem_rdata = 32'h0BADF00D;
    drive(0, 32'h50, 0, 4'hF);
    @(negedge clk);
    chk("rs_c1_ren", read_en_to_ctrl, 1);
    #2 reset = 1;
    #1;
    chk("rs_ren", read_en_to_ctrl, 0);
    chk("rs_ctrl", ctrl_ack, 0);
    chk("rs_dat", wb_dat_o, 0);
    chk("rs_adr", mem_addr, 0);
    chk("rs_ack", wb_ack_o, 0);
    idle();
    @(negedge clk);
    reset = 0;
    mem_rdata = 32'h600DCAFE;
    drive(0, 32'h60, 0, 4'hF);
    @(negedge clk);
    chk("rs2_c1_adr", mem_addr, 32'h60);
    @(negedge clk);
    chk("rs2_c2_ack", wb_ack_o, 0);
    @(negedge clk);
    chk("rs2_c3_ack", wb_ack_o, 1);
    chk("rs2_c3_dat", wb_dat_o, 32'h600DCAFE);
    idle();
    @(negedge clk);
    // back-to-back reads with strobe held
    mem_rdata = 32'hA1A1A1A1;
    drive(0, 32'h70, 0, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ackv[k] = wb_ack_o;
      if (k == 4) mem_rdata = 32'hB2B2B2B2;
    end
    idle();
    chk("bb_ack3", ackv[3], 1);
    chk("bb_ack4", ackv[4], 0);
    chk("bb_ack5", ackv[5], 0);
    chk("bb_ack6", ackv[6], 0);
    chk("bb_ack7", ackv[7], 1);
    chk("bb_ack8", ackv[8], 0);
    chk("bb_dat", wb_dat_o, 32'hB2B2B2B2);
    @(negedge clk);
`ifdef WB_SLAVE_ERR_EN
    drive(0, 32'h4000, 0, 4'hF);
    @(negedge clk);
    chk("er_c1_err", wb_err_o, 1);
    chk("er_c1_ack", wb_ack_o, 0);
    chk("er_c1_ctrl", ctrl_ack, 0);
    chk("er_c1_adr", mem_addr, 32'h70);
    idle();
    @(negedge clk);
    chk("er_c2_err", wb_err_o, 0);
    chk("er_c2_ack", wb_ack_o, 0);
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
